multi_input_channel_buffer: RTL and testbench
=============================================

# multi_input_channel_buffer

Parametrised, multi-channel successor to the single-channel input buffer. It holds NUM_CHANNELS independent packet FIFOs of arbitrary (non-power-of-two) depth between the inbound links and the processing element's input-channel logic. Per channel, it exposes head and next-packet peeks, an occupancy count and a synchronous flush. Link acknowledge is gated by enable and flush, so no packet is acknowledged without being stored.

## Interface
Parameters:
- NUM_CHANNELS, default 4: number of independent input channels, ≥1.
- FIFO_DEPTH, default TIA_CHANNEL_BUFFER_FIFO_DEPTH: entries per channel, any value ≥2.
- PACKET_WIDTH, default TIA_PACKET_WIDTH: bits per packet.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  positive-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  active-high; when low, no state changes.
- link_req  in  NUM_CHANNELS  per-channel sender has a valid packet.
- link_packet  in  NUM_CHANNELS×PACKET_WIDTH  inbound packets.
- link_ack  out  NUM_CHANNELS  per-channel buffer can accept this cycle.
- channel_flush  in  NUM_CHANNELS  synchronous per-channel clear.
- channel_dequeue  in  NUM_CHANNELS  pop head.
- channel_packet  out  NUM_CHANNELS×PACKET_WIDTH  head entry.
- channel_next_packet  out  NUM_CHANNELS×PACKET_WIDTH  entry behind head, 0 if count<2.
- channel_empty  out  NUM_CHANNELS  count==0.
- channel_count  out  NUM_CHANNELS×$clog2(FIFO_DEPTH+1)  occupancy.
- underflow_error  out  NUM_CHANNELS  sticky dequeue-on-empty flag. See Configuration.
- quiescent  out  1  AND of all channel_empty.

## Operation
- Per channel c:
  - Transfer when enable && link_req[c] && link_ack[c].
  - Pop when enable && channel_dequeue[c] && !empty[c].
- link_ack[c] = reset_n && enable && !flush[c] && (count[c] != FIFO_DEPTH). This is a combinational function of those inputs and registered count. It does not depend on dequeue.
- Transfer and pop in the same cycle: the packet is written at tail, head and tail both advance, and count is unchanged.
- When full, a pop does not enable a same-cycle transfer, because ack is already low. The slot becomes available on the next cycle.
- Dequeue on empty is ignored; no pointer or count change.
- Flush has priority over transfer and pop: head=tail=0, count=0. The link packet in a flush cycle is not acked and not stored.
- Pointer arithmetic: head, tail and neck wrap explicitly from FIFO_DEPTH-1 to 0, using a compare, not modulo-2^n overflow. neck = wrap(head+1).
- Count never exceeds FIFO_DEPTH and never goes below 0.
- Channels are fully independent. There is no arbitration between channels.
- Storage contents are not reset. Outputs derived from storage are only meaningful when count qualifies them.

## Timing
- Reset values while reset_n is low, and after reset:
  - All counts and pointers 0; empty=all 1s; quiescent=1.
  - link_ack=0 while reset_n is low, then 1 from the first enabled cycle.
  - underflow_error=0.
  - channel_packet is undefined storage content; channel_next_packet=0.
- Enqueue latency: a packet accepted at edge N is visible on channel_packet after edge N, when the FIFO was empty. count increments at the same edge.
- Pop takes effect at the edge. The new head is visible the next cycle.
- Reset asserted mid-operation clears state immediately (asynchronously). In-flight packets are lost, and ack drops in the same cycle.
- enable low freezes all state. Ack is held low, so the sender stalls and nothing is lost.

## Configuration
- Macro TIA_INPUT_BUFFER_UNDERFLOW_CHECK_EN.
- Defined: underflow_error[c] sets on any enabled channel_dequeue[c] while empty[c]. It clears only on reset_n or flush[c].
- Undefined: underflow_error is tied to 0 and no flop is generated. Dequeue on empty remains silently ignored.

## Structure
- Shared interconnect package holds:
  - TIA_CHANNEL_BUFFER_FIFO_DEPTH and TIA_PACKET_WIDTH.
  - A channel_count_t typedef sized $clog2(FIFO_DEPTH+1).
- One natural sub-module, input_channel_fifo: a single-channel FIFO with flush, peek, count, ack and underflow flag. It is instantiated NUM_CHANNELS times in a generate loop.
- The top level concatenates the per-channel outputs and reduces quiescent.

## Test plan
- Reset then fill: FIFO_DEPTH=3, push A,B,C on ch0 → count 1,2,3; ack=0 after third push; packet=A; next=B; quiescent=0.
- Wrap with non-power-of-two depth: depth 3, do 5 push/pop pairs on ch1 → data returned in order, count returns to 0, pointers wrap past 2.
- Simultaneous push+pop at count 2 → count stays 2; head advances; new tail entry present after two further pops.
- Flush with link_req=1: channel_flush[2] asserted with 2 entries → ack[2]=0 that cycle; next cycle count=0, empty=1; the offered packet is not stored.
- Pop on empty with macro defined → count stays 0; underflow_error[3]=1 and stays set until flush. With macro undefined → remains 0.
- enable low with link_req high → ack=0, counts frozen. Async reset_n pulse mid-stream → all counts 0 and ack=0 within the same cycle.

Source files
------------

// File: rtl/multi_input_channel_buffer_pkg.sv
// Shared interconnect definitions for the input-channel buffers: default depth, packet width
// and the occupancy count type.
package multi_input_channel_buffer_pkg;

    localparam int TIA_CHANNEL_BUFFER_FIFO_DEPTH = 4;
    localparam int TIA_PACKET_WIDTH              = 32;
    localparam int CHANNEL_COUNT_W               = $clog2(TIA_CHANNEL_BUFFER_FIFO_DEPTH + 1);

    typedef logic [CHANNEL_COUNT_W-1:0] channel_count_t;

endpackage

// File: rtl/multi_input_channel_buffer_input_channel_fifo.sv
// Single-channel packet FIFO of arbitrary depth with flush, head/next peeks, count and link ack.
// Optional sticky underflow flag under TIA_INPUT_BUFFER_UNDERFLOW_CHECK_EN.
module input_channel_fifo
    import multi_input_channel_buffer_pkg::*;
#(
    parameter int DEPTH = TIA_CHANNEL_BUFFER_FIFO_DEPTH,
    parameter int WIDTH = TIA_PACKET_WIDTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             link_req,
    input  logic [WIDTH-1:0] link_packet,
    output logic             link_ack,
    input  logic             flush,
    input  logic             dequeue,
    output logic [WIDTH-1:0] packet,
    output logic [WIDTH-1:0] next_packet,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             underflow_error
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    neck;
    logic             push;
    logic             pop;

    // Depth need not be a power of two, so wrap on compare rather than on overflow.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty       = (count == '0);
    assign link_ack    = reset_n && enable && !flush && (count != FULL);
    assign push        = link_req && link_ack;
    assign pop         = enable && !flush && dequeue && !empty;
    assign neck        = wrap_inc(head);
    assign packet      = mem[head];
    assign next_packet = (count >= CW'(2)) ? mem[neck] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (enable) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= wrap_inc(tail);
                if (pop)  head <= wrap_inc(head);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    // Storage is deliberately left out of reset; count qualifies what is visible.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= link_packet;
    end

`ifdef TIA_INPUT_BUFFER_UNDERFLOW_CHECK_EN
    logic underflow_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow_q <= 1'b0;
        end else if (enable) begin
            if (flush)                 underflow_q <= 1'b0;
            else if (dequeue && empty) underflow_q <= 1'b1;
        end
    end

    assign underflow_error = underflow_q;
`else
    assign underflow_error = 1'b0;
`endif

endmodule

// File: rtl/multi_input_channel_buffer.sv
// NUM_CHANNELS independent input-channel FIFOs with flattened per-channel outputs and a
// quiescent reduction. Underflow flags are built only with TIA_INPUT_BUFFER_UNDERFLOW_CHECK_EN.
module multi_input_channel_buffer
    import multi_input_channel_buffer_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int FIFO_DEPTH   = TIA_CHANNEL_BUFFER_FIFO_DEPTH,
    parameter int PACKET_WIDTH = TIA_PACKET_WIDTH,
    parameter int COUNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic [NUM_CHANNELS-1:0]            link_req,
    input  logic [NUM_CHANNELS*PACKET_WIDTH-1:0] link_packet,
    output logic [NUM_CHANNELS-1:0]            link_ack,
    input  logic [NUM_CHANNELS-1:0]            channel_flush,
    input  logic [NUM_CHANNELS-1:0]            channel_dequeue,
    output logic [NUM_CHANNELS*PACKET_WIDTH-1:0] channel_packet,
    output logic [NUM_CHANNELS*PACKET_WIDTH-1:0] channel_next_packet,
    output logic [NUM_CHANNELS-1:0]            channel_empty,
    output logic [NUM_CHANNELS*COUNT_W-1:0]    channel_count,
    output logic [NUM_CHANNELS-1:0]            underflow_error,
    output logic                               quiescent
);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
        input_channel_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (PACKET_WIDTH),
            .CW    (COUNT_W)
        ) u_fifo (
            .clock           (clock),
            .reset_n         (reset_n),
            .enable          (enable),
            .link_req        (link_req[c]),
            .link_packet     (link_packet[c*PACKET_WIDTH +: PACKET_WIDTH]),
            .link_ack        (link_ack[c]),
            .flush           (channel_flush[c]),
            .dequeue         (channel_dequeue[c]),
            .packet          (channel_packet[c*PACKET_WIDTH +: PACKET_WIDTH]),
            .next_packet     (channel_next_packet[c*PACKET_WIDTH +: PACKET_WIDTH]),
            .empty           (channel_empty[c]),
            .count           (channel_count[c*COUNT_W +: COUNT_W]),
            .underflow_error (underflow_error[c])
        );
    end

    assign quiescent = &channel_empty;

endmodule

// File: tb/tb_multi_input_channel_buffer.sv
// Scoreboard bench for multi_input_channel_buffer at depth 3 across four channels.
module tb_multi_input_channel_buffer;

    localparam int NC = 4;
    localparam int D  = 3;
    localparam int W  = 16;
    localparam int CW = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [NC-1:0]     link_req;
    logic [NC*W-1:0]   link_packet;
    logic [NC-1:0]     link_ack;
    logic [NC-1:0]     channel_flush;
    logic [NC-1:0]     channel_dequeue;
    logic [NC*W-1:0]   channel_packet;
    logic [NC*W-1:0]   channel_next_packet;
    logic [NC-1:0]     channel_empty;
    logic [NC*CW-1:0]  channel_count;
    logic [NC-1:0]     underflow_error;
    logic              quiescent;

    logic [W-1:0] sb [NC][$];
    logic [NC-1:0] um;
    int tests_run = 0;
    int tests_failed = 0;

    multi_input_channel_buffer #(
        .NUM_CHANNELS (NC),
        .FIFO_DEPTH   (D),
        .PACKET_WIDTH (W)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .enable              (enable),
        .link_req            (link_req),
        .link_packet         (link_packet),
        .link_ack            (link_ack),
        .channel_flush       (channel_flush),
        .channel_dequeue     (channel_dequeue),
        .channel_packet      (channel_packet),
        .channel_next_packet (channel_next_packet),
        .channel_empty       (channel_empty),
        .channel_count       (channel_count),
        .underflow_error     (underflow_error),
        .quiescent           (quiescent)
    );

    always #5 clock = ~clock;

    function automatic logic [NC*CW-1:0] model_counts();
        logic [NC*CW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*CW +: CW] = CW'(sb[c].size());
        return v;
    endfunction

    function automatic logic [NC-1:0] exp_uf();
`ifdef TIA_INPUT_BUFFER_UNDERFLOW_CHECK_EN
        return um;
`else
        return '0;
`endif
    endfunction

    // Advance one clock edge, updating the scoreboard from the stimulus currently driven.
    task automatic tick();
        logic [NC-1:0] do_push, do_pop, do_flush, do_uf;
        logic [W-1:0]  tmp;
        for (int c = 0; c < NC; c++) begin
            do_flush[c] = enable && channel_flush[c];
            do_push[c]  = enable && link_req[c] && !channel_flush[c] && (sb[c].size() != D);
            do_pop[c]   = enable && channel_dequeue[c] && !channel_flush[c] && (sb[c].size() != 0);
            do_uf[c]    = enable && channel_dequeue[c] && (sb[c].size() == 0);
        end
        @(posedge clock);
        for (int c = 0; c < NC; c++) begin
            if (do_flush[c]) begin
                sb[c].delete();
                um[c] = 1'b0;
            end else begin
                if (do_pop[c])  tmp = sb[c].pop_front();
                if (do_push[c]) sb[c].push_back(link_packet[c*W +: W]);
                if (do_uf[c])   um[c] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; link_req = '1; link_packet = '1;
        channel_flush = '0; channel_dequeue = '0; um = '0;
        #2;
        tests_run++;
        if (link_ack !== 4'h0) begin tests_failed++; $display("FAIL reset_ack got %h want 0", link_ack); end
        tests_run++;
        if (channel_empty !== 4'hF || quiescent !== 1'b1) begin
            tests_failed++; $display("FAIL reset_empty got %h/%b want f/1", channel_empty, quiescent);
        end
        tests_run++;
        if (channel_count !== '0 || channel_next_packet !== '0 || underflow_error !== '0) begin
            tests_failed++;
            $display("FAIL reset_state cnt %h next %h uf %h want 0", channel_count, channel_next_packet, underflow_error);
        end
        repeat (2) @(posedge clock);
        #1; reset_n = 1'b1; link_req = '0;
        #1;
        tests_run++;
        if (link_ack !== 4'hF) begin tests_failed++; $display("FAIL post_reset_ack got %h want f", link_ack); end
    endtask

    task automatic test_fill();
        logic [W-1:0] vals [3] = '{16'hA00A, 16'hB00B, 16'hC00C};
        link_req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            link_packet[0 +: W] = vals[i];
            #1;
            tests_run++;
            if (link_ack[0] !== 1'b1) begin tests_failed++; $display("FAIL fill_ack%0d got %b want 1", i, link_ack[0]); end
            tick();
            tests_run++;
            if (channel_count[0 +: CW] !== CW'(i + 1)) begin
                tests_failed++; $display("FAIL fill_count%0d got %0d want %0d", i, channel_count[0 +: CW], i + 1);
            end
        end
        link_packet[0 +: W] = 16'hDEAD;
        #1;
        tests_run++;
        if (link_ack[0] !== 1'b0) begin tests_failed++; $display("FAIL full_ack got %b want 0", link_ack[0]); end
        tick();
        tests_run++;
        if (channel_count[0 +: CW] !== CW'(3)) begin tests_failed++; $display("FAIL full_count got %0d want 3", channel_count[0 +: CW]); end
        tests_run++;
        if (channel_packet[0 +: W] !== 16'hA00A || channel_next_packet[0 +: W] !== 16'hB00B) begin
            tests_failed++; $display("FAIL fill_peek got %h/%h want a00a/b00b", channel_packet[0 +: W], channel_next_packet[0 +: W]);
        end
        tests_run++;
        if (quiescent !== 1'b0) begin tests_failed++; $display("FAIL fill_quiescent got %b want 0", quiescent); end
        link_req[0] = 1'b0;
        channel_dequeue[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (channel_packet[0 +: W] !== sb[0][0]) begin
                tests_failed++; $display("FAIL drain%0d got %h want %h", i, channel_packet[0 +: W], sb[0][0]);
            end
            tick();
        end
        channel_dequeue[0] = 1'b0;
        tests_run++;
        if (channel_empty[0] !== 1'b1 || channel_next_packet[0 +: W] !== '0) begin
            tests_failed++; $display("FAIL drain_empty got %b/%h want 1/0", channel_empty[0], channel_next_packet[0 +: W]);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            link_req[1] = 1'b1; link_packet[W +: W] = 16'h1100 + W'(i);
            tick();
            link_req[1] = 1'b0; channel_dequeue[1] = 1'b1;
            #1;
            tests_run++;
            if (channel_packet[W +: W] !== sb[1][0] || channel_packet[W +: W] !== 16'h1100 + W'(i)) begin
                tests_failed++; $display("FAIL wrap%0d got %h want %h", i, channel_packet[W +: W], 16'h1100 + W'(i));
            end
            tick();
            channel_dequeue[1] = 1'b0;
        end
        tests_run++;
        if (channel_count[CW +: CW] !== '0 || channel_empty[1] !== 1'b1) begin
            tests_failed++; $display("FAIL wrap_end got %0d/%b want 0/1", channel_count[CW +: CW], channel_empty[1]);
        end
    endtask

    task automatic test_back_to_back();
        link_req[2] = 1'b1;
        link_packet[2*W +: W] = 16'h2001; tick();
        link_packet[2*W +: W] = 16'h2002; tick();
        link_packet[2*W +: W] = 16'h2003; channel_dequeue[2] = 1'b1;
        #1;
        tests_run++;
        if (link_ack[2] !== 1'b1) begin tests_failed++; $display("FAIL b2b_ack got %b want 1", link_ack[2]); end
        tick();
        link_req[2] = 1'b0; channel_dequeue[2] = 1'b0;
        tests_run++;
        if (channel_count[2*CW +: CW] !== CW'(2) || channel_packet[2*W +: W] !== 16'h2002) begin
            tests_failed++; $display("FAIL b2b_state got %0d/%h want 2/2002", channel_count[2*CW +: CW], channel_packet[2*W +: W]);
        end
        channel_dequeue[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (channel_packet[2*W +: W] !== sb[2][0]) begin
                tests_failed++; $display("FAIL b2b_pop%0d got %h want %h", i, channel_packet[2*W +: W], sb[2][0]);
            end
            tick();
        end
        channel_dequeue[2] = 1'b0;
        tests_run++;
        if (sb[2].size() != 0 || channel_empty[2] !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_tail got empty %b want 1", channel_empty[2]);
        end
    endtask

    task automatic test_flush();
        link_req[2] = 1'b1;
        link_packet[2*W +: W] = 16'h2004; tick();
        link_packet[2*W +: W] = 16'h2005; tick();
        link_packet[2*W +: W] = 16'h2BAD; channel_flush[2] = 1'b1;
        #1;
        tests_run++;
        if (link_ack[2] !== 1'b0) begin tests_failed++; $display("FAIL flush_ack got %b want 0", link_ack[2]); end
        tick();
        channel_flush[2] = 1'b0; link_req[2] = 1'b0;
        tests_run++;
        if (channel_count[2*CW +: CW] !== '0 || channel_empty[2] !== 1'b1) begin
            tests_failed++; $display("FAIL flush_state got %0d/%b want 0/1", channel_count[2*CW +: CW], channel_empty[2]);
        end
        tick();
        tests_run++;
        if (channel_count !== model_counts()) begin
            tests_failed++; $display("FAIL flush_nostore got %h want %h", channel_count, model_counts());
        end
    endtask

    task automatic test_underflow();
        channel_dequeue[3] = 1'b1;
        tick();
        channel_dequeue[3] = 1'b0;
        tests_run++;
        if (channel_count[3*CW +: CW] !== '0) begin tests_failed++; $display("FAIL uf_count got %0d want 0", channel_count[3*CW +: CW]); end
        tests_run++;
        if (underflow_error !== exp_uf()) begin tests_failed++; $display("FAIL uf_set got %h want %h", underflow_error, exp_uf()); end
        tick(); tick();
        tests_run++;
        if (underflow_error !== exp_uf()) begin tests_failed++; $display("FAIL uf_sticky got %h want %h", underflow_error, exp_uf()); end
        channel_flush[3] = 1'b1;
        tick();
        channel_flush[3] = 1'b0;
        tests_run++;
        if (underflow_error !== 4'h0) begin tests_failed++; $display("FAIL uf_clear got %h want 0", underflow_error); end
    endtask

    task automatic test_enable();
        link_req[0] = 1'b1; link_packet[0 +: W] = 16'h0E01;
        tick();
        enable = 1'b0; link_req = '1; channel_dequeue = '1;
        #1;
        tests_run++;
        if (link_ack !== 4'h0) begin tests_failed++; $display("FAIL en_ack got %h want 0", link_ack); end
        tick(); tick();
        tests_run++;
        if (channel_count !== model_counts() || channel_count !== 8'h01) begin
            tests_failed++; $display("FAIL en_frozen got %h want 01", channel_count);
        end
        tests_run++;
        if (underflow_error !== 4'h0) begin tests_failed++; $display("FAIL en_uf got %h want 0", underflow_error); end
        enable = 1'b1; link_req = '0; channel_dequeue = 4'h1;
        #1;
        tests_run++;
        if (channel_packet[0 +: W] !== 16'h0E01) begin tests_failed++; $display("FAIL en_head got %h want 0e01", channel_packet[0 +: W]); end
        tick();
        channel_dequeue = '0;
    endtask

    task automatic test_async_reset();
        link_req[1] = 1'b1; link_packet[W +: W] = 16'h5151;
        tick(); tick();
        tests_run++;
        if (channel_count[CW +: CW] !== CW'(2)) begin tests_failed++; $display("FAIL ar_pre got %0d want 2", channel_count[CW +: CW]); end
        #3; reset_n = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) sb[c].delete();
        um = '0;
        tests_run++;
        if (channel_count !== '0 || link_ack !== 4'h0 || quiescent !== 1'b1) begin
            tests_failed++; $display("FAIL async_reset cnt %h ack %h q %b want 0/0/1", channel_count, link_ack, quiescent);
        end
        #2; reset_n = 1'b1; link_req = '0;
        tick();
        tests_run++;
        if (channel_count !== '0 || link_ack !== 4'hF) begin
            tests_failed++; $display("FAIL ar_post cnt %h ack %h want 0/f", channel_count, link_ack);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_underflow();
        test_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
